// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// Module : regfile_wb_arbiter_if
// Brief  : Requester-side and register-file-side signal bundle for the arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
);
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [3*AW-1:0] req_adr;
  logic [3*DW-1:0] req_data;
  logic            rf_regwrite;
  logic [AW-1:0]   rf_adr_rd;
  logic [DW-1:0]   rf_din_rd;
  logic [1:0]      last_grant;
  logic [CW-1:0]   wr_cnt;

  modport slave (
    input  req_valid, req_adr, req_data,
    output req_ready, rf_regwrite, rf_adr_rd, rf_din_rd, last_grant, wr_cnt
  );

  modport master (
    output req_valid, req_adr, req_data,
    input  req_ready, rf_regwrite, rf_adr_rd, rf_din_rd, last_grant, wr_cnt
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Round-robin 3-way register-file writeback arbiter with write counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  regfile_wb_arbiter_if.slave bus
);

  logic [1:0]    lg_q;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] din_q;
  logic [CW-1:0] cnt_q;

  logic [1:0]    start;
  logic [2:0]    cand;
  logic [2:0]    grant;
  logic [1:0]    win;
  logic          found;
  logic          transfer;
  logic [AW-1:0] adr_d;
  logic [DW-1:0] din_d;
  logic          we_d;

  // Rotating search: first valid requester at or after last_grant+1 (mod 3).
  always_comb begin
    grant = 3'b000;
    win   = 2'd0;
    found = 1'b0;
    cand  = 3'd0;
    start = (lg_q == 2'd2) ? 2'd0 : lg_q + 2'd1;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, start} + 3'(k);
      if (cand > 3'd2) cand = cand - 3'd3;
      if (!found && bus.req_valid[cand[1:0]]) begin
        found             = 1'b1;
        win               = cand[1:0];
        grant[cand[1:0]]  = 1'b1;
      end
    end
    if (rst) begin
      grant = 3'b000;
      found = 1'b0;
    end
  end

  assign transfer = found;

  always_comb begin
    adr_d = bus.req_adr[AW-1:0];
    din_d = bus.req_data[DW-1:0];
    case (win)
      2'd1: begin
        adr_d = bus.req_adr[2*AW-1:AW];
        din_d = bus.req_data[2*DW-1:DW];
      end
      2'd2: begin
        adr_d = bus.req_adr[3*AW-1:2*AW];
        din_d = bus.req_data[3*DW-1:2*DW];
      end
      default: ;
    endcase
    // Writes to x0 are accepted but never committed.
    we_d = transfer && (adr_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lg_q  <= 2'd2;
      we_q  <= 1'b0;
      adr_q <= '0;
      din_q <= '0;
      cnt_q <= '0;
    end else begin
      we_q <= we_d;
      if (transfer) begin
        lg_q  <= win;
        adr_q <= adr_d;
        din_q <= din_d;
      end
      if (we_d && (cnt_q != {CW{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.req_ready   = grant;
  assign bus.rf_regwrite = we_q;
  assign bus.rf_adr_rd   = adr_q;
  assign bus.rf_din_rd   = din_q;
  assign bus.last_grant  = lg_q;
  assign bus.wr_cnt      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module : tb_regfile_wb_arbiter
// Brief  : Directed table, corner sequences and randomized model check.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DW(DW), .AW(AW), .CW(CW)) mif ();
  regfile_wb_arbiter_if #(.DW(DW), .AW(AW), .CW(2))  sif ();

  assign sif.req_valid = mif.req_valid;
  assign sif.req_adr   = mif.req_adr;
  assign sif.req_data  = mif.req_data;

  regfile_wb_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut     (.clk(clk), .rst(rst), .bus(mif));
  regfile_wb_arbiter #(.DW(DW), .AW(AW), .CW(2))  dut_sat (.clk(clk), .rst(rst), .bus(sif));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference state: pointer, pending write, committed counts, wait ages.
  logic [1:0]    m_lg;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_din;
  int            m_cnt, m_cnt2;
  int            m_wait [3];

  task automatic apply(input logic [2:0] v, input logic [AW-1:0] a0, a1, a2,
                       input logic [DW-1:0] d0, d1, d2);
    mif.req_valid = v;
    mif.req_adr   = {a2, a1, a0};
    mif.req_data  = {d2, d1, d0};
  endtask

  function automatic int model_pick(input logic [2:0] v);
    for (int k = 1; k <= 3; k++) begin
      if (v[(int'(m_lg) + k) % 3]) return (int'(m_lg) + k) % 3;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    apply(3'b000, '0, '0, '0, '0, '0, '0);
    @(posedge clk); #1;
    check("rst_ready", 64'(mif.req_ready),   64'd0);
    check("rst_we",    64'(mif.rf_regwrite), 64'd0);
    check("rst_adr",   64'(mif.rf_adr_rd),   64'd0);
    check("rst_din",   64'(mif.rf_din_rd),   64'd0);
    check("rst_lg",    64'(mif.last_grant),  64'd2);
    check("rst_cnt",   64'(mif.wr_cnt),      64'd0);
    check("rst_cnt2",  64'(sif.wr_cnt),      64'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    m_lg   = 2'd2;
    m_we   = 1'b0;
    m_adr  = '0;
    m_din  = '0;
    m_cnt  = 0;
    m_cnt2 = 0;
    for (int i = 0; i < 3; i++) m_wait[i] = 0;
  endtask

  // One cycle against the model; inputs already applied at posedge+1.
  task automatic model_cycle(output int pick);
    logic [2:0] er;
    #3;
    pick = model_pick(mif.req_valid);
    er   = (pick < 0) ? 3'b000 : 3'(1 << pick);
    check("rnd_ready", 64'(mif.req_ready), 64'(er));
    for (int i = 0; i < 3; i++) begin
      if (pick == i) begin
        check("rnd_fair", 64'(m_wait[i] < 3), 64'd1);
        m_wait[i] = 0;
      end else if (mif.req_valid[i]) m_wait[i]++;
      else m_wait[i] = 0;
    end
    @(posedge clk); #1;
    if (pick >= 0) begin
      m_lg  = 2'(pick);
      m_adr = mif.req_adr[pick*AW +: AW];
      m_din = mif.req_data[pick*DW +: DW];
      m_we  = (m_adr != 0);
    end else m_we = 1'b0;
    if (m_we) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    check("rnd_we",   64'(mif.rf_regwrite), 64'(m_we));
    check("rnd_adr",  64'(mif.rf_adr_rd),   64'(m_adr));
    check("rnd_din",  64'(mif.rf_din_rd),   64'(m_din));
    check("rnd_lg",   64'(mif.last_grant),  64'(m_lg));
    check("rnd_cnt",  64'(mif.wr_cnt),      64'(m_cnt));
    check("rnd_cnt2", 64'(sif.wr_cnt),      64'(m_cnt2));
  endtask

  typedef struct {
    logic [2:0]    v;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] d0, d1, d2;
    logic [2:0]    rdy;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] din;
    logic [1:0]    lg;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int pick;
    int sat_exp [5];
    logic [2:0]    cv;
    logic [AW-1:0] ca [3];
    logic [DW-1:0] cd [3];

    // Contention, single request, idle, x0 write, pointer hold across idles.
    tbl[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1'b1, 5'd1, 32'hA0, 2'd0, 16'd1};
    tbl[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1'b1, 5'd2, 32'hA1, 2'd1, 16'd2};
    tbl[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1'b1, 5'd3, 32'hA2, 2'd2, 16'd3};
    tbl[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1'b1, 5'd1, 32'hA0, 2'd0, 16'd4};
    tbl[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b010, 1'b1, 5'd2, 32'hA1, 2'd1, 16'd5};
    tbl[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 3'b100, 1'b1, 5'd3, 32'hA2, 2'd2, 16'd6};
    tbl[6]  = '{3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 16'd7};
    tbl[7]  = '{3'b000, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd0, 16'd7};
    tbl[8]  = '{3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0, 3'b010, 1'b0, 5'd0, 32'h1234, 2'd1, 16'd7};
    tbl[9]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 32'h1234, 2'd1, 16'd7};
    tbl[10] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 32'h1234, 2'd1, 16'd7};
    tbl[11] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 32'h1234, 2'd1, 16'd7};
    tbl[12] = '{3'b011, 5'd9, 5'd10, 5'd0, 32'h99, 32'hAA, 32'h0, 3'b001, 1'b1, 5'd9, 32'h99, 2'd0, 16'd8};

    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

    do_reset();
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      #3;
      check($sformatf("tbl%0d_ready", i), 64'(mif.req_ready), 64'(tbl[i].rdy));
      @(posedge clk); #1;
      check($sformatf("tbl%0d_we", i),  64'(mif.rf_regwrite), 64'(tbl[i].we));
      check($sformatf("tbl%0d_adr", i), 64'(mif.rf_adr_rd),   64'(tbl[i].adr));
      check($sformatf("tbl%0d_din", i), 64'(mif.rf_din_rd),   64'(tbl[i].din));
      check($sformatf("tbl%0d_lg", i),  64'(mif.last_grant),  64'(tbl[i].lg));
      check($sformatf("tbl%0d_cnt", i), 64'(mif.wr_cnt),      64'(tbl[i].cnt));
    end

    // First write after reset, then hold on idle.
    do_reset();
    apply(3'b001, 5'd5, '0, '0, 32'hDEADBEEF, '0, '0);
    #3;
    check("single_ready", 64'(mif.req_ready), 64'b001);
    @(posedge clk); #1;
    check("single_we",  64'(mif.rf_regwrite), 64'd1);
    check("single_adr", 64'(mif.rf_adr_rd),   64'd5);
    check("single_din", 64'(mif.rf_din_rd),   64'hDEADBEEF);
    check("single_cnt", 64'(mif.wr_cnt),      64'd1);
    apply(3'b000, '0, '0, '0, '0, '0, '0);
    @(posedge clk); #1;
    check("idle_we",  64'(mif.rf_regwrite), 64'd0);
    check("idle_adr", 64'(mif.rf_adr_rd),   64'd5);
    check("idle_din", 64'(mif.rf_din_rd),   64'hDEADBEEF);

    // Asynchronous reset lands while a registered write is pending.
    apply(3'b100, '0, '0, 5'd7, '0, '0, 32'h77);
    #3;
    check("mid_ready", 64'(mif.req_ready), 64'b100);
    @(posedge clk); #1;
    check("mid_we_pending", 64'(mif.rf_regwrite), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_we",    64'(mif.rf_regwrite), 64'd0);
    check("mid_adr",   64'(mif.rf_adr_rd),   64'd0);
    check("mid_din",   64'(mif.rf_din_rd),   64'd0);
    check("mid_cnt",   64'(mif.wr_cnt),      64'd0);
    check("mid_lg",    64'(mif.last_grant),  64'd2);
    check("mid_rdy0",  64'(mif.req_ready),   64'd0);
    apply(3'b000, '0, '0, '0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_we", 64'(mif.rf_regwrite), 64'd0);

    // Counter saturation on the narrow-counter instance.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(3'b001, 5'(i + 1), '0, '0, 32'(i), '0, '0);
      @(posedge clk); #1;
      check($sformatf("sat%0d_cnt2", i), 64'(sif.wr_cnt), 64'(sat_exp[i]));
      check($sformatf("sat%0d_cnt", i),  64'(mif.wr_cnt), 64'(i + 1));
    end

    // Randomized traffic; an ungranted request holds its address and data.
    do_reset();
    cv   = 3'b000;
    pick = -1;
    for (int i = 0; i < 3; i++) begin
      ca[i] = '0;
      cd[i] = '0;
    end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(cv[i] && pick != i)) begin
          cv[i] = ($urandom_range(0, 99) < 60);
          ca[i] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
          cd[i] = $urandom;
        end
      end
      apply(cv, ca[0], ca[1], ca[2], cd[0], cd[1], cd[2]);
      model_cycle(pick);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
